cpu_controller: RTL and testbench

Eight-phase instruction sequencer for the accumulator CPU. It steps each instruction through address, fetch, load, decode, operand and execute phases, and drives the register and memory control strobes. It sits directly upstream of the ALU and accumulator. It consumes the instruction-register opcode and the ALU's `a_is_zero` flag, and produces the load, read and write enables that make the ALU result land in the accumulator, PC or memory.

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/cpu_controller.sv | 139 +++++++++++++
 tb/tb_cpu_controller.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the accumulator CPU: opcode constants (also used by
// the ALU), the sequencer state encoding, and the helper that identifies the
// opcodes whose result goes through the ALU into the accumulator.
// -----------------------------------------------------------------------------
package cpu_pkg;

  // Opcode encoding, shared with the ALU
  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  // Phases 0..7 are encoded by their phase number so the low three bits
  // double as the debug phase; HALTED sits outside that range.
  typedef enum logic [3:0] {
    ST_INST_ADDR  = 4'd0,
    ST_INST_FETCH = 4'd1,
    ST_INST_LOAD  = 4'd2,
    ST_IDLE       = 4'd3,
    ST_OP_ADDR    = 4'd4,
    ST_OP_FETCH   = 4'd5,
    ST_ALU_OP     = 4'd6,
    ST_STORE      = 4'd7,
    ST_HALTED     = 4'd8
  } state_t;

  // True for opcodes that read an operand and load the accumulator
  function automatic logic is_aluop(input logic [2:0] op);
    logic r;
    case (op)
      OP_ADD, OP_AND, OP_XOR, OP_LDA: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_controller.sv
// -----------------------------------------------------------------------------
// cpu_controller
// Eight-phase instruction sequencer for the accumulator CPU. A state register
// steps through the eight phases on every enabled clock; a combinational
// decode of state, opcode and zero drives the register/memory strobes.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   enable  in   phase-advance enable (0 = hold phase and outputs)
//   opcode  in   [2:0] instruction-register opcode
//   zero    in   accumulator-is-zero flag from the ALU
//   sel     out  address mux select (1 = PC, 0 = IR operand address)
//   rd      out  memory read enable
//   ld_ir   out  instruction register load
//   inc_pc  out  program counter increment
//   ld_pc   out  program counter load (jump)
//   ld_ac   out  accumulator load from ALU
//   wr      out  memory write strobe
//   data_e  out  accumulator drives the data bus
//   halt    out  CPU halted
//   phase   out  [2:0] current phase (7 while halted)
// -----------------------------------------------------------------------------
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int NUM_PHASES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);

  state_t r_state;
  state_t w_next_state;
  logic   w_aluop;

  assign w_aluop = is_aluop(opcode);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INST_ADDR;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: advance one phase per enabled cycle; HLT diverts to HALTED
  always_comb begin
    w_next_state = r_state;
    if (enable) begin
      case (r_state)
        ST_INST_ADDR:  w_next_state = ST_INST_FETCH;
        ST_INST_FETCH: w_next_state = ST_INST_LOAD;
        ST_INST_LOAD:  w_next_state = ST_IDLE;
        ST_IDLE:       w_next_state = ST_OP_ADDR;
        ST_OP_ADDR:    w_next_state = (opcode == OP_HLT) ? ST_HALTED : ST_OP_FETCH;
        ST_OP_FETCH:   w_next_state = ST_ALU_OP;
        ST_ALU_OP:     w_next_state = ST_STORE;
        ST_STORE:      w_next_state = ST_INST_ADDR;
        ST_HALTED:     w_next_state = ST_HALTED;
        default:       w_next_state = ST_INST_ADDR;
      endcase
    end else begin
      w_next_state = r_state;
    end
  end

  // Output decode; outputs track state directly so stalls hold them
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    case (r_state)
      ST_INST_ADDR: begin
        sel = 1'b1;
      end
      ST_INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      ST_INST_LOAD, ST_IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      ST_OP_ADDR: begin
        inc_pc = 1'b1;
        halt   = (opcode == OP_HLT);
      end
      ST_OP_FETCH: begin
        rd = w_aluop;
      end
      ST_ALU_OP: begin
        rd     = w_aluop;
        inc_pc = (opcode == OP_SKZ) && zero;
        ld_pc  = (opcode == OP_JMP);
        data_e = (opcode == OP_STO);
      end
      ST_STORE: begin
        rd     = w_aluop;
        ld_ac  = w_aluop;
        inc_pc = (opcode == OP_JMP);
        ld_pc  = (opcode == OP_JMP);
        wr     = (opcode == OP_STO);
        data_e = (opcode == OP_STO);
      end
      ST_HALTED: begin
        halt = 1'b1;
      end
      default: begin
        sel = 1'b0;
      end
    endcase
  end

  // Debug phase: the phase number, pinned to the last phase while halted
  assign phase = (r_state == ST_HALTED) ? 3'(NUM_PHASES - 1) : r_state[2:0];

endmodule

// File: tb/tb_cpu_controller.sv
// -----------------------------------------------------------------------------
// tb_cpu_controller
// Randomized self-checking bench for cpu_controller. A phase-counter model
// (integer phase plus a halted flag) predicts the state, and a per-signal
// rule table derived from the instruction timing predicts every strobe.
// -----------------------------------------------------------------------------
module tb_cpu_controller;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0] phase;

  int total = 0;
  int bad   = 0;
  int m_phase  = 0;
  bit m_halted = 1'b0;

  logic [11:0] observed;
  logic [11:0] exp_v;

  cpu_controller #(.NUM_PHASES(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e),
    .halt   (halt),
    .phase  (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign observed = {phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};

  // Expected {phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}
  function automatic logic [11:0] expected(int ph, bit hl, logic [2:0] op, logic z);
    bit alu, run;
    logic [2:0] p;
    logic e_sel, e_rd, e_ldir, e_inc, e_ldpc, e_ldac, e_wr, e_de, e_halt;
    alu    = (op >= 3'd2) && (op <= 3'd5);
    run    = !hl;
    p      = hl ? 3'd7 : 3'(ph);
    e_sel  = run && (ph <= 3);
    e_rd   = run && ((ph >= 1 && ph <= 3) || (alu && ph >= 5));
    e_ldir = run && (ph == 2 || ph == 3);
    e_inc  = run && (ph == 4 || (ph == 6 && op == 3'd1 && z) || (ph == 7 && op == 3'd7));
    e_ldpc = run && (op == 3'd7) && (ph >= 6);
    e_ldac = run && alu && (ph == 7);
    e_wr   = run && (op == 3'd6) && (ph == 7);
    e_de   = run && (op == 3'd6) && (ph >= 6);
    e_halt = hl || (ph == 4 && op == 3'd0);
    return {p, e_sel, e_rd, e_ldir, e_inc, e_ldpc, e_ldac, e_wr, e_de, e_halt};
  endfunction

  // Advance the reference model by one rising edge
  task automatic model_edge();
    if (!rst_n) begin
      m_phase  = 0;
      m_halted = 1'b0;
    end else if (!m_halted && enable) begin
      if (m_phase == 4 && opcode == 3'd0) m_halted = 1'b1;
      else m_phase = (m_phase + 1) % 8;
    end
  endtask

  // One clock: edge, model update, then settle before sampling
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b1;
    opcode = 3'd2;
    zero   = 1'b0;
    m_phase = 0;
    m_halted = 1'b0;
    #3;
    for (int i = 0; i < 3; i++) begin
      exp_v = expected(m_phase, m_halted, opcode, zero);
      total++;
      if (observed !== exp_v) begin
        bad++;
        $display("FAIL reset[%0d] t=%0t got=%h want=%h", i, $time, observed, exp_v);
      end
      tick();
    end
    rst_n = 1'b1;
    #1;
    exp_v = expected(m_phase, m_halted, opcode, zero);
    total++;
    if (observed !== exp_v || phase !== 3'd0 || sel !== 1'b1) begin
      bad++;
      $display("FAIL reset_release got=%h want=%h", observed, exp_v);
    end
  endtask

  // One full instruction per opcode; zero mode 0/1 forced, 2 random
  task automatic test_opcodes();
    logic [2:0] ops [8] = '{3'd2, 3'd6, 3'd1, 3'd1, 3'd7, 3'd3, 3'd4, 3'd5};
    int         zm  [8] = '{2, 2, 1, 0, 2, 2, 2, 2};
    enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      opcode = ops[k];
      for (int c = 0; c < 8; c++) begin
        zero = (zm[k] == 2) ? 1'($urandom_range(0, 1)) : 1'(zm[k]);
        #1;
        exp_v = expected(m_phase, m_halted, opcode, zero);
        total++;
        if (observed !== exp_v) begin
          bad++;
          $display("FAIL opcode%0d_ph%0d got=%h want=%h", opcode, m_phase, observed, exp_v);
        end
        tick();
      end
    end
  endtask

  // Stall three cycles in phase 5, then resume into phase 6
  task automatic test_stall_phase5();
    enable = 1'b1;
    opcode = 3'd2;
    for (int i = 0; i < 16 && m_phase != 5; i++) tick();
    total++;
    if (phase !== 3'd5) begin
      bad++;
      $display("FAIL stall_reach got=%0d want=5", phase);
    end
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) enable = 1'b1;
      tick();
      zero = 1'($urandom_range(0, 1));
      #1;
      exp_v = expected(m_phase, m_halted, opcode, zero);
      total++;
      if (observed !== exp_v || phase !== ((i == 3) ? 3'd6 : 3'd5)) begin
        bad++;
        $display("FAIL stall[%0d] got=%h want=%h", i, observed, exp_v);
      end
    end
  endtask

  // Reset asserted between edges in phase 6 takes effect without a clock
  task automatic test_async_reset();
    enable = 1'b1;
    opcode = 3'd7;
    for (int i = 0; i < 16 && m_phase != 6; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    m_phase = 0;
    m_halted = 1'b0;
    exp_v = expected(m_phase, m_halted, opcode, zero);
    total++;
    if (observed !== exp_v || phase !== 3'd0) begin
      bad++;
      $display("FAIL async_reset got=%h want=%h", observed, exp_v);
    end
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  // HLT: halt pulse in phase 4, then HALTED for 25 cycles, then reset out
  task automatic test_halt();
    opcode = 3'd0;
    enable = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (c >= 5) enable = 1'($urandom_range(0, 1));
      zero = 1'($urandom_range(0, 1));
      #1;
      exp_v = expected(m_phase, m_halted, opcode, zero);
      total++;
      if (observed !== exp_v) begin
        bad++;
        $display("FAIL halt[%0d] got=%h want=%h", c, observed, exp_v);
      end
      tick();
    end
    total++;
    if (halt !== 1'b1 || phase !== 3'd7) begin
      bad++;
      $display("FAIL halted_hold got=%b/%0d want=1/7", halt, phase);
    end
    #2;
    rst_n = 1'b0;
    #1;
    m_phase = 0;
    m_halted = 1'b0;
    exp_v = expected(m_phase, m_halted, opcode, zero);
    total++;
    if (observed !== exp_v || halt !== 1'b0 || sel !== 1'b1) begin
      bad++;
      $display("FAIL halt_reset got=%h want=%h", observed, exp_v);
    end
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  // Random enable, zero and opcode (opcode changes only at phase 0)
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      enable = ($urandom_range(0, 3) != 0);
      zero   = 1'($urandom_range(0, 1));
      if (m_phase == 0 && !m_halted) opcode = 3'($urandom_range(1, 7));
      #1;
      exp_v = expected(m_phase, m_halted, opcode, zero);
      total++;
      if (observed !== exp_v) begin
        bad++;
        $display("FAIL random[%0d] got=%h want=%h", c, observed, exp_v);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_opcodes();
    test_stall_phase5();
    test_async_reset();
    test_halt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
